// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath enables and mux selects for a unified-memory datapath.
module mips_multicycle_ctrl #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_opcode;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= state_t'(RESET_STATE);
            r_opcode <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_opcode <= opcode;
            end
        end
    end

    always_comb begin
        w_next     = S_FETCH;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        PCSrc      = 2'b00;
        PCEn       = 1'b0;
        illegal_op = 1'b0;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b01;
                IRWrite = mem_ready;
                PCEn    = mem_ready;
                w_next  = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                ALUOp   = 2'b01;
                // Decode uses the live IR; the latched copy is valid from the next state on.
                case (opcode)
                    OP_LW, OP_SW:   w_next = S_MEMADR;
                    OP_RTYPE:       w_next = S_EXECUTE;
                    OP_ADDI:        w_next = S_ADDIEX;
                    OP_BEQ, OP_BNE: w_next = S_BRANCH;
                    OP_J:           w_next = S_JUMP;
                    default: begin
                        w_next     = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b01;
                if (r_opcode == OP_LW) begin
                    w_next = S_MEMRD;
                end else if (r_opcode == OP_SW) begin
                    w_next = S_MEMWR;
                end
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                w_next  = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                w_next   = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                PCSrc   = 2'b01;
                if (r_opcode == OP_BNE) begin
                    ALUOp = 2'b11;
                    PCEn  = ~zero;
                end else begin
                    ALUOp = 2'b10;
                    PCEn  = zero;
                end
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b01;
                w_next  = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
            end
            S_JUMP: begin
                PCSrc = 2'b10;
                PCEn  = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    assign state_o = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: per-cycle expected output vectors
// are queued as stimulus is applied and checked before the next clock edge.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic       PCEn, illegal_op;
    logic [3:0] state_o;

    localparam logic [5:0] RT = 6'b000000, ADDI = 6'b001000, LW = 6'b100011;
    localparam logic [5:0] SW = 6'b101011, BEQ = 6'b000100, BNE = 6'b000101;
    localparam logic [5:0] J  = 6'b000010, BAD = 6'b111111;

    typedef struct {
        string       tag;
        logic [19:0] v;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.RESET_STATE(4'd0)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn),
        .illegal_op(illegal_op), .state_o(state_o)
    );

    // Field order: IorD MemRead MemWrite IRWrite RegDst MemtoReg RegWrite ALUSrcA
    //              ALUSrcB ALUOp PCSrc PCEn illegal_op state
    function automatic logic [19:0] ev(input logic [3:0] st, input logic pcen,
                                       input logic irw, input logic ill,
                                       input logic [1:0] brop);
        logic iord = 0, mr = 0, mw = 0, ir = 0, rd = 0, m2r = 0, rw = 0, sa = 0, pe = 0;
        logic [1:0] sb = 2'b00, op = 2'b00, ps = 2'b00;
        case (st)
            4'd0:  begin mr = 1; sb = 2'b01; op = 2'b01; pe = pcen; ir = irw; end
            4'd1:  begin sb = 2'b11; op = 2'b01; end
            4'd2:  begin sa = 1; sb = 2'b10; op = 2'b01; end
            4'd3:  begin mr = 1; iord = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mw = 1; iord = 1; end
            4'd6:  begin sa = 1; end
            4'd7:  begin rw = 1; rd = 1; end
            4'd8:  begin sa = 1; ps = 2'b01; op = brop; pe = pcen; end
            4'd9:  begin sa = 1; sb = 2'b10; op = 2'b01; end
            4'd10: begin rw = 1; end
            4'd11: begin ps = 2'b10; pe = 1; end
            default: ;
        endcase
        return {iord, mr, mw, ir, rd, m2r, rw, sa, sb, op, ps, pe, ill, st};
    endfunction

    function automatic logic [19:0] s(input logic [3:0] st);
        return ev(st, 1'b0, 1'b0, 1'b0, 2'b00);
    endfunction

    task automatic cyc(input string tag, input logic [5:0] op, input logic z,
                       input logic rdy, input logic [19:0] e);
        exp_t item;
        exp_t got;
        logic [19:0] obs;
        opcode    = op;
        zero      = z;
        mem_ready = rdy;
        item.tag  = tag;
        item.v    = e;
        q.push_back(item);
        #2;
        obs = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
               ALUSrcB, ALUOp, PCSrc, PCEn, illegal_op, state_o};
        got = q.pop_front();
        n_cmp++;
        assert (obs === got.v) else begin
            n_err++;
            $error("FAIL %s: observed %05h expected %05h", got.tag, obs, got.v);
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        cyc("reset_state", RT, 0, 0, s(4'd0));
        reset = 1'b0;

        // LW zero-wait; IR changes after DECODE must not redirect MEMADR
        cyc("lw_fetch",  LW, 0, 1, ev(4'd0, 1, 1, 0, 2'b00));
        cyc("lw_decode", LW, 0, 1, s(4'd1));
        cyc("lw_memadr", SW, 0, 1, s(4'd2));
        cyc("lw_memrd",  SW, 0, 1, s(4'd3));
        cyc("lw_memwb",  SW, 0, 1, s(4'd4));

        // SW with two wait cycles in MEMWR; mem_ready low in MEMADR is ignored
        cyc("sw_fetch",  SW, 0, 1, ev(4'd0, 1, 1, 0, 2'b00));
        cyc("sw_decode", SW, 0, 1, s(4'd1));
        cyc("sw_memadr", SW, 0, 0, s(4'd2));
        cyc("sw_wait1",  SW, 0, 0, s(4'd5));
        cyc("sw_wait2",  SW, 0, 0, s(4'd5));
        cyc("sw_memwr",  SW, 0, 1, s(4'd5));

        // Branch condition: all four BEQ/BNE x zero cases
        cyc("beq1_fetch",  BEQ, 0, 1, ev(4'd0, 1, 1, 0, 2'b00));
        cyc("beq1_decode", BEQ, 0, 1, s(4'd1));
        cyc("beq_z1",      BEQ, 1, 1, ev(4'd8, 1, 0, 0, 2'b10));
        cyc("beq0_fetch",  BEQ, 0, 1, ev(4'd0, 1, 1, 0, 2'b00));
        cyc("beq0_decode", BEQ, 0, 1, s(4'd1));
        cyc("beq_z0",      BEQ, 0, 1, ev(4'd8, 0, 0, 0, 2'b10));
        cyc("bne0_fetch",  BNE, 0, 1, ev(4'd0, 1, 1, 0, 2'b00));
        cyc("bne0_decode", BNE, 0, 1, s(4'd1));
        cyc("bne_z0",      RT,  0, 1, ev(4'd8, 1, 0, 0, 2'b11));
        cyc("bne1_fetch",  BNE, 0, 1, ev(4'd0, 1, 1, 0, 2'b00));
        cyc("bne1_decode", BNE, 0, 1, s(4'd1));
        cyc("bne_z1",      BNE, 1, 1, ev(4'd8, 0, 0, 0, 2'b11));

        // R-type then J back to back
        cyc("rt_fetch",   RT, 0, 1, ev(4'd0, 1, 1, 0, 2'b00));
        cyc("rt_decode",  RT, 0, 1, s(4'd1));
        cyc("rt_execute", RT, 0, 1, s(4'd6));
        cyc("rt_aluwb",   RT, 0, 1, s(4'd7));
        cyc("j_fetch",    J,  0, 1, ev(4'd0, 1, 1, 0, 2'b00));
        cyc("j_decode",   J,  0, 1, s(4'd1));
        cyc("j_jump",     J,  0, 1, s(4'd11));

        // ADDI
        cyc("addi_fetch",  ADDI, 0, 1, ev(4'd0, 1, 1, 0, 2'b00));
        cyc("addi_decode", ADDI, 0, 1, s(4'd1));
        cyc("addi_ex",     ADDI, 0, 1, s(4'd9));
        cyc("addi_wb",     ADDI, 0, 1, s(4'd10));

        // Illegal opcode, then a three-cycle fetch stall
        cyc("ill_fetch",  BAD, 0, 1, ev(4'd0, 1, 1, 0, 2'b00));
        cyc("ill_decode", BAD, 0, 1, ev(4'd1, 0, 0, 1, 2'b00));
        cyc("stall1",     BAD, 0, 0, s(4'd0));
        cyc("stall2",     BAD, 0, 0, s(4'd0));
        cyc("stall3",     BAD, 0, 0, s(4'd0));

        // LW with a read wait state, aborted by reset in MEMRD
        cyc("ab_fetch",  LW, 0, 1, ev(4'd0, 1, 1, 0, 2'b00));
        cyc("ab_decode", LW, 0, 1, s(4'd1));
        cyc("ab_memadr", LW, 0, 1, s(4'd2));
        cyc("ab_memrd",  LW, 0, 0, s(4'd3));
        reset = 1'b1;
        cyc("ab_rst_cyc", LW, 0, 1, s(4'd3));
        reset = 1'b0;
        cyc("ab_after",   LW, 0, 0, s(4'd0));
        cyc("ab_resume",  LW, 0, 1, ev(4'd0, 1, 1, 0, 2'b00));
        cyc("ab_decode2", LW, 0, 1, s(4'd1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
